// File: rtl/seg_scan_decoder.sv
// Purpose: decodes a multiplexed 7-segment scan (anode/led) back into a BCD frame.
// Latency: anode edge to capture 2+SETTLE_CYCLES+1 cycles, final capture to frame_done 1 cycle.
// Backpressure: none, it is a passive monitor. Optional macro SEG_DECODE_HEX_EN adds A..F decode.
module seg_scan_decoder #(
    parameter int NUM_DIGITS     = 3,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] anode,
    input  logic [7:0] led,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [3:0] hundred,
    output logic [3:0] thousands,
    output logic [3:0] dp,
    output logic [3:0] blank,
    output logic       frame_valid,
    output logic       frame_done,
    output logic       seg_err,
    output logic       scan_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    localparam logic [7:0]  SETTLE_W = SETTLE_CYCLES[7:0];
    localparam logic [15:0] TO_W     = TIMEOUT_CYCLES[15:0];
    localparam logic [3:0]  DIG_MASK = 4'((1 << NUM_DIGITS) - 1);

    // Returns {undecodable, blank, value} for a 7-bit active-low segment pattern.
    function automatic logic [5:0] seg_decode(input logic [6:0] p);
        logic [5:0] r;
        case (p)
            7'h40: r = {2'b00, 4'd0};
            7'h79: r = {2'b00, 4'd1};
            7'h24: r = {2'b00, 4'd2};
            7'h30: r = {2'b00, 4'd3};
            7'h19: r = {2'b00, 4'd4};
            7'h12: r = {2'b00, 4'd5};
            7'h02: r = {2'b00, 4'd6};
            7'h78: r = {2'b00, 4'd7};
            7'h00: r = {2'b00, 4'd8};
            7'h10: r = {2'b00, 4'd9};
            7'h7F: r = {2'b01, 4'd0};
`ifdef SEG_DECODE_HEX_EN
            7'h08: r = {2'b00, 4'hA};
            7'h03: r = {2'b00, 4'hB};
            7'h46: r = {2'b00, 4'hC};
            7'h21: r = {2'b00, 4'hD};
            7'h06: r = {2'b00, 4'hE};
            7'h0E: r = {2'b00, 4'hF};
`endif
            default: r = {2'b10, 4'hF};
        endcase
        return r;
    endfunction

    logic [3:0]       anode_m_q, anode_s_q, anode_prev_q;
    logic [7:0]       led_m_q, led_s_q;
    state_t           state_q, state_d;
    logic [3:0]       anode_cap_q, anode_cap_d;
    logic [1:0]       dig_q, dig_d;
    logic [7:0]       settle_q, settle_d;
    logic [15:0]      to_q, to_d;
    logic [3:0]       seen_q, seen_d;
    logic [3:0][3:0]  sh_val_q, sh_val_d;
    logic [3:0]       sh_dp_q, sh_dp_d;
    logic [3:0]       sh_blank_q, sh_blank_d;
    logic [3:0][3:0]  out_val_q, out_val_d;
    logic [3:0]       dp_q, dp_d;
    logic [3:0]       blank_q, blank_d;
    logic             fv_q, fv_d;
    logic             fd_q, fd_d;

    logic [3:0] anode_low;
    logic       multi_low, one_low, dig_ok, publish;
    logic [1:0] idx;
    logic [5:0] dec;

    // Two-flop synchronizers; idle values (all high) so reset does not look like a scan fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_m_q    <= 4'hF;
            anode_s_q    <= 4'hF;
            anode_prev_q <= 4'hF;
            led_m_q      <= 8'hFF;
            led_s_q      <= 8'hFF;
        end else begin
            anode_m_q    <= anode;
            anode_s_q    <= anode_m_q;
            anode_prev_q <= anode_s_q;
            led_m_q      <= led;
            led_s_q      <= led_m_q;
        end
    end

    // Classify the synced anode: how many digits are enabled and which one.
    always_comb begin
        anode_low = ~anode_s_q;
        multi_low = (anode_low & (anode_low - 4'd1)) != 4'd0;
        one_low   = (anode_low != 4'd0) && !multi_low;
        idx       = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (anode_low[i]) idx = 2'(i);
        end
        dig_ok    = {30'd0, idx} < NUM_DIGITS;
        dec       = seg_decode(led_s_q[6:0]);
        publish   = (seen_q & DIG_MASK) == DIG_MASK;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            anode_cap_q <= 4'd0;
            dig_q       <= 2'd0;
            settle_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            anode_cap_q <= anode_cap_d;
            dig_q       <= dig_d;
            settle_q    <= settle_d;
        end
    end

    // FSM next state: settle on a stable one-hot anode, capture once, hold until it moves.
    always_comb begin
        state_d     = state_q;
        anode_cap_d = anode_cap_q;
        dig_d       = dig_q;
        settle_d    = settle_q;
        scan_err    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (multi_low) begin
                    // Only flag the first cycle of a given bad pattern, not every cycle it persists.
                    scan_err = (anode_s_q != anode_prev_q);
                end else if (one_low && dig_ok) begin
                    anode_cap_d = anode_s_q;
                    dig_d       = idx;
                    settle_d    = 8'd1;
                    state_d     = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (anode_s_q != anode_cap_q) begin
                    settle_d = 8'd0;
                    state_d  = S_IDLE;
                end else if (settle_q >= SETTLE_W) begin
                    state_d = S_CAPTURE;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            S_CAPTURE: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (anode_s_q != anode_cap_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign seg_err = (state_q == S_CAPTURE) && dec[5];

    // Frame datapath: timeout, publish of a complete frame, and per-digit shadow capture.
    always_comb begin
        seen_d     = seen_q;
        to_d       = to_q;
        sh_val_d   = sh_val_q;
        sh_dp_d    = sh_dp_q;
        sh_blank_d = sh_blank_q;
        out_val_d  = out_val_q;
        dp_d       = dp_q;
        blank_d    = blank_q;
        fv_d       = fv_q;
        fd_d       = 1'b0;

        if (to_q != TO_W) to_d = to_q + 16'd1;

        if (to_q == TO_W) begin
            // Stale: drop validity and any partial frame, but keep the digit outputs.
            fv_d   = 1'b0;
            seen_d = 4'd0;
        end

        if (publish) begin
            for (int i = 0; i < 4; i++) begin
                out_val_d[i] = DIG_MASK[i] ? sh_val_q[i] : 4'd0;
            end
            dp_d    = sh_dp_q & DIG_MASK;
            blank_d = sh_blank_q & DIG_MASK;
            fd_d    = 1'b1;
            fv_d    = 1'b1;
            seen_d  = 4'd0;
        end

        if (state_q == S_CAPTURE) begin
            sh_val_d[dig_q]   = dec[3:0];
            sh_blank_d[dig_q] = dec[4];
            sh_dp_d[dig_q]    = ~led_s_q[7];
            seen_d[dig_q]     = 1'b1;
            to_d              = 16'd0;
        end
    end

    // Frame datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q     <= 4'd0;
            to_q       <= 16'd0;
            sh_val_q   <= '0;
            sh_dp_q    <= 4'd0;
            sh_blank_q <= 4'd0;
            out_val_q  <= '0;
            dp_q       <= 4'd0;
            blank_q    <= 4'd0;
            fv_q       <= 1'b0;
            fd_q       <= 1'b0;
        end else begin
            seen_q     <= seen_d;
            to_q       <= to_d;
            sh_val_q   <= sh_val_d;
            sh_dp_q    <= sh_dp_d;
            sh_blank_q <= sh_blank_d;
            out_val_q  <= out_val_d;
            dp_q       <= dp_d;
            blank_q    <= blank_d;
            fv_q       <= fv_d;
            fd_q       <= fd_d;
        end
    end

    assign ones        = out_val_q[0];
    assign tens        = out_val_q[1];
    assign hundred     = out_val_q[2];
    assign thousands   = out_val_q[3];
    assign dp          = dp_q;
    assign blank       = blank_q;
    assign frame_valid = fv_q;
    assign frame_done  = fd_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Purpose: directed self-checking bench for seg_scan_decoder (3 digits, settle 4, timeout 100).
// Latency: drives 10-cycle digit dwells on a 40 ns clock and checks frames after each scan.
// Backpressure: none; pulse outputs are counted on the falling edge.
module tb_seg_scan_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] anode = 4'hF;
    logic [7:0] led = 8'hFF;
    logic [3:0] ones, tens, hundred, thousands, dp, blank;
    logic       frame_valid, frame_done, seg_err, scan_err;

    int n_tests = 0;
    int n_fail  = 0;
    int fd_cnt  = 0;
    int se_cnt  = 0;
    int sc_cnt  = 0;

    always #20 clk = ~clk;

    seg_scan_decoder #(
        .NUM_DIGITS    (3),
        .SETTLE_CYCLES (4),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .anode      (anode),
        .led        (led),
        .ones       (ones),
        .tens       (tens),
        .hundred    (hundred),
        .thousands  (thousands),
        .dp         (dp),
        .blank      (blank),
        .frame_valid(frame_valid),
        .frame_done (frame_done),
        .seg_err    (seg_err),
        .scan_err   (scan_err)
    );

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (seg_err)    se_cnt++;
        if (scan_err)   sc_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic dwell(input logic [3:0] a, input logic [7:0] l, input int n);
        anode = a;
        led   = l;
        cyc(n);
    endtask

    task automatic scan3(input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2);
        dwell(4'b1110, l0, 10);
        dwell(4'b1101, l1, 10);
        dwell(4'b1011, l2, 10);
        dwell(4'b1111, 8'hFF, 3);
    endtask

    int         fd0, se0, sc0, lat, fell;
    logic [3:0] exp_tens_hex;
    int         exp_se_hex;

    initial begin
`ifdef SEG_DECODE_HEX_EN
        exp_tens_hex = 4'hA;
        exp_se_hex   = 0;
`else
        exp_tens_hex = 4'hF;
        exp_se_hex   = 1;
`endif
        // Reset state
        cyc(3);
        check("rst_ones", ones, 0);
        check("rst_thousands", thousands, 0);
        check("rst_valid", frame_valid, 0);
        rst_n = 1'b1;
        cyc(2);
        check("post_rst_digits", {ones, tens, hundred, dp, blank}, 0);
        check("post_rst_flags", {frame_valid, frame_done, seg_err, scan_err}, 0);

        // Basic frame 4/7/6 with latency window on the final digit
        fd0 = fd_cnt; se0 = se_cnt; lat = 0;
        dwell(4'b1110, 8'h99, 10);
        dwell(4'b1101, 8'hF8, 10);
        anode = 4'b1011;
        led   = 8'h82;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (frame_done && lat == 0) lat = k;
        end
        #1;
        dwell(4'b1111, 8'hFF, 3);
        check("f1_done_cnt", fd_cnt - fd0, 1);
        check("f1_latency_ok", (lat >= 8 && lat <= 11) ? 1 : 0, 1);
        check("f1_ones", ones, 4);
        check("f1_tens", tens, 7);
        check("f1_hundred", hundred, 6);
        check("f1_thousands", thousands, 0);
        check("f1_valid", frame_valid, 1);
        check("f1_seg_err", se_cnt - se0, 0);
        check("f1_dp_blank", {dp, blank}, 0);

        // Anode glitch: 2-cycle tens select must not be captured
        fd0 = fd_cnt;
        dwell(4'b1110, 8'hC0, 10);
        dwell(4'b1011, 8'hA4, 10);
        dwell(4'b1101, 8'hB0, 2);
        dwell(4'b1111, 8'hFF, 6);
        check("glitch_no_frame", fd_cnt - fd0, 0);
        check("glitch_hundred_kept", hundred, 6);
        dwell(4'b1101, 8'hF9, 10);
        dwell(4'b1111, 8'hFF, 3);
        check("glitch_done_cnt", fd_cnt - fd0, 1);
        check("glitch_digits", {ones, tens, hundred}, {4'd0, 4'd1, 4'd2});

        // Two anodes low
        sc0 = sc_cnt; fd0 = fd_cnt;
        dwell(4'b1100, 8'hFF, 10);
        dwell(4'b1111, 8'hFF, 4);
        check("scan_err_pulses", sc_cnt - sc0, 1);
        check("scan_err_no_frame", fd_cnt - fd0, 0);
        check("scan_err_valid", frame_valid, 1);

        // Undecodable tens pattern, dp on ones
        se0 = se_cnt; fd0 = fd_cnt;
        scan3(8'h19, 8'h8C, 8'h82);
        check("seg_err_pulses", se_cnt - se0, 1);
        check("seg_err_tens", tens, 4'hF);
        check("seg_err_others", {ones, hundred}, {4'd4, 4'd6});
        check("seg_err_dp", dp, 4'b0001);
        check("seg_err_done_cnt", fd_cnt - fd0, 1);

        // Hex pattern on tens, blank hundred
        se0 = se_cnt;
        scan3(8'h99, 8'h88, 8'hFF);
        check("hex_tens", tens, exp_tens_hex);
        check("hex_seg_err", se_cnt - se0, exp_se_hex);
        check("blank_mask", blank, 4'b0100);
        check("blank_hundred", hundred, 0);

        // Timeout with scanning stopped
        fd0 = fd_cnt;
        cyc(85);
        check("to_still_valid", frame_valid, 1);
        fell = 0;
        for (int k = 0; k < 30; k++) begin
            if (!frame_valid && fell == 0) fell = 1;
            cyc(1);
        end
        check("to_valid_fell", fell, 1);
        check("to_digits_kept", {ones, tens, hundred}, {4'd4, exp_tens_hex, 4'd0});
        check("to_no_frame", fd_cnt - fd0, 0);
        scan3(8'h99, 8'hF8, 8'h82);
        check("to_resume_valid", frame_valid, 1);
        check("to_resume_done", fd_cnt - fd0, 1);

        // Reset after two of three digits
        dwell(4'b1110, 8'hC0, 10);
        dwell(4'b1101, 8'hF9, 10);
        anode = 4'hF;
        led   = 8'hFF;
        rst_n = 1'b0;
        #5;
        check("mid_rst_valid", frame_valid, 0);
        check("mid_rst_digits", {ones, tens, hundred}, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        fd0 = fd_cnt;
        dwell(4'b1011, 8'hA4, 10);
        dwell(4'b1111, 8'hFF, 3);
        check("mid_rst_partial", fd_cnt - fd0, 0);
        check("mid_rst_still_invalid", frame_valid, 0);
        scan3(8'hC0, 8'hF9, 8'hA4);
        check("mid_rst_done", fd_cnt - fd0, 1);
        check("mid_rst_frame", {ones, tens, hundred, 3'b000, frame_valid}, {4'd0, 4'd1, 4'd2, 4'd1});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
